// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Operands are latched at start; the result lands in HI/LO when the busy window expires.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  MDCCtrl,
   input  logic [1:0]  MDM_WE,
   input  logic [1:0]  MDM_RE,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] MDM_out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   // state | meaning
   // IDLE  | waiting for start; HI/LO writable from A
   // RUN   | operation in flight; counter expiring commits HI/LO
   typedef enum logic {IDLE, RUN} state_t;

   localparam int CW = 16;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MADD  = 3'b100;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     a_q, b_q;
   logic [2:0]      op_q;
   logic [31:0]     hi_q, lo_q, hi_d, lo_d;
   logic            launch;
   logic            op_legal, op_is_div;

   logic [63:0]     prod_s, prod_u, madd_sum;
   logic            neg_a, neg_b, div_zero;
   logic [31:0]     mag_a, mag_b, divisor_s, divisor_u;
   logic [31:0]     uq_s, ur_s, q_s, r_s, q_u, r_u;
   logic [31:0]     res_hi, res_lo;
   logic            res_we;

   assign op_legal  = (MDCCtrl <= OP_MADD);
   assign op_is_div = (MDCCtrl == OP_DIV) || (MDCCtrl == OP_DIVU);

   // Signed product of sign-extended operands: low 64 bits are exact.
   assign prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u   = {32'b0, a_q} * {32'b0, b_q};
   assign madd_sum = {hi_q, lo_q} + prod_s;

   // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   assign neg_a     = a_q[31];
   assign neg_b     = b_q[31];
   assign div_zero  = (b_q == 32'b0);
   assign mag_a     = neg_a ? (32'b0 - a_q) : a_q;
   assign mag_b     = neg_b ? (32'b0 - b_q) : b_q;
   assign divisor_s = div_zero ? 32'd1 : mag_b;
   assign divisor_u = div_zero ? 32'd1 : b_q;
   assign uq_s      = mag_a / divisor_s;
   assign ur_s      = mag_a % divisor_s;
   assign q_s       = (neg_a ^ neg_b) ? (32'b0 - uq_s) : uq_s;
   assign r_s       = neg_a ? (32'b0 - ur_s) : ur_s;
   assign q_u       = a_q / divisor_u;
   assign r_u       = a_q % divisor_u;

   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      res_we = 1'b0;
      unique case (op_q)
         OP_MULT:  begin {res_hi, res_lo} = prod_s;   res_we = 1'b1; end
         OP_MULTU: begin {res_hi, res_lo} = prod_u;   res_we = 1'b1; end
         OP_MADD:  begin {res_hi, res_lo} = madd_sum; res_we = 1'b1; end
         OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_we = !div_zero; end
         OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_we = !div_zero; end
         default:  res_we = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      launch  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && op_legal) begin
               launch  = 1'b1;
               state_d = RUN;
               cnt_d   = op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (MDM_WE == 2'b01) begin
               hi_d = A;
            end else if (MDM_WE == 2'b10) begin
               lo_d = A;
            end
         end
         RUN: begin
            if (cnt_q <= CW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (res_we) begin
                  hi_d = res_hi;
                  lo_d = res_lo;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         if (launch) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= MDCCtrl;
         end
      end
   end

   assign busy = (state_q == RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

   always_comb begin
      unique case (MDM_RE)
         2'b01:   MDM_out = hi_q;
         2'b10:   MDM_out = lo_q;
         default: MDM_out = 32'b0;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  MDCCtrl = 3'b0;
   logic [1:0]  MDM_WE = 2'b0;
   logic [1:0]  MDM_RE = 2'b0;
   logic [31:0] A = 32'b0;
   logic [31:0] B = 32'b0;
   logic        busy;
   logic [31:0] MDM_out, HI, LO;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .MDCCtrl(MDCCtrl),
      .MDM_WE(MDM_WE), .MDM_RE(MDM_RE), .A(A), .B(B),
      .busy(busy), .MDM_out(MDM_out), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   // Reference model: remaining busy cycles plus architectural HI/LO.
   logic [31:0] m_hi = 32'b0, m_lo = 32'b0, m_a = 32'b0, m_b = 32'b0;
   logic [2:0]  m_op = 3'b0;
   int          m_left = 0;

   always @(posedge clk) begin
      longint sa, sb, q, r;
      logic [63:0] p;
      if (reset) begin
         m_hi = 0; m_lo = 0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            sa = longint'($signed(m_a));
            sb = longint'($signed(m_b));
            case (m_op)
               3'd0: {m_hi, m_lo} = sa * sb;
               3'd1: begin p = {32'b0, m_a} * {32'b0, m_b}; {m_hi, m_lo} = p; end
               3'd4: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
               3'd2: if (m_b != 0) begin
                  q = sa / sb; r = sa % sb;
                  m_lo = q[31:0]; m_hi = r[31:0];
               end
               3'd3: if (m_b != 0) begin
                  m_lo = m_a / m_b; m_hi = m_a % m_b;
               end
               default: ;
            endcase
         end
      end else if (start && MDCCtrl <= 3'd4) begin
         m_op = MDCCtrl; m_a = A; m_b = B;
         m_left = (MDCCtrl == 3'd2 || MDCCtrl == 3'd3) ? 10 : 5;
      end else if (MDM_WE == 2'b01) begin
         m_hi = A;
      end else if (MDM_WE == 2'b10) begin
         m_lo = A;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] exp_out;
      if (checking) begin
         exp_out = (MDM_RE == 2'b01) ? m_hi : (MDM_RE == 2'b10) ? m_lo : 32'b0;
         chk("model_busy", {31'b0, busy}, {31'b0, m_left > 0});
         chk("model_hi", HI, m_hi);
         chk("model_lo", LO, m_lo);
         chk("model_mdm_out", MDM_out, exp_out);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op and count busy cycles; optionally poke start/MDM_WE mid-run.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere, output int n);
      MDCCtrl = op; A = a; B = b; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (interfere && n == 2) begin
            start = 1'b1; MDCCtrl = 3'b011; MDM_WE = 2'b01; A = 32'h1234;
         end else if (interfere && n == 3) begin
            start = 1'b0; MDM_WE = 2'b00;
         end
         step();
      end
      if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      checking = 1'b1;
      chk("reset_hi", HI, 32'h0);
      chk("reset_lo", LO, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'h0);

      run_op(3'b000, 32'hFFFFFFFE, 32'd3, 1'b0, n);
      chk("mult_cycles", 32'(n), 32'd5);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFFA);

      run_op(3'b001, 32'hFFFFFFFE, 32'd3, 1'b0, n);
      chk("multu_cycles", 32'(n), 32'd5);
      chk("multu_hi", HI, 32'h00000002);
      chk("multu_lo", LO, 32'hFFFFFFFA);

      run_op(3'b010, 32'hFFFFFFF9, 32'd2, 1'b0, n);
      chk("div_cycles", 32'(n), 32'd10);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);

      run_op(3'b010, 32'hFFFFFFF9, 32'd0, 1'b0, n);
      chk("div0_cycles", 32'(n), 32'd10);
      chk("div0_lo", LO, 32'hFFFFFFFD);
      chk("div0_hi", HI, 32'hFFFFFFFF);

      run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
      chk("divmin_lo", LO, 32'h80000000);
      chk("divmin_hi", HI, 32'h00000000);

      run_op(3'b011, 32'd100, 32'd7, 1'b0, n);
      chk("divu_cycles", 32'(n), 32'd10);
      chk("divu_lo", LO, 32'd14);
      chk("divu_hi", HI, 32'd2);

      // start and MDM_WE together: write is dropped, div by zero keeps HI/LO
      MDM_WE = 2'b10;
      run_op(3'b011, 32'h0000ABCD, 32'd0, 1'b0, n);
      MDM_WE = 2'b00;
      chk("startwe_lo", LO, 32'd14);
      chk("startwe_hi", HI, 32'd2);

      MDCCtrl = 3'b101; A = 32'd9; B = 32'd9; start = 1'b1;
      step();
      start = 1'b0;
      chk("illegal_busy", {31'b0, busy}, 32'h0);
      step();
      chk("illegal_lo", LO, 32'd14);

      MDM_WE = 2'b01; A = 32'h0; step();
      MDM_WE = 2'b10; A = 32'hFFFFFFFF; step();
      MDM_WE = 2'b00;
      chk("mtlo_lo", LO, 32'hFFFFFFFF);
      run_op(3'b100, 32'd1, 32'd1, 1'b0, n);
      chk("madd_cycles", 32'(n), 32'd5);
      chk("madd_hi", HI, 32'd1);
      chk("madd_lo", LO, 32'd0);
      MDM_RE = 2'b10; #1;
      chk("madd_read_lo", MDM_out, 32'd0);
      MDM_RE = 2'b01; #1;
      chk("madd_read_hi", MDM_out, 32'd1);
      MDM_RE = 2'b00;

      run_op(3'b000, 32'hFFFFFFFE, 32'd3, 1'b1, n);
      chk("interf_cycles", 32'(n), 32'd5);
      chk("interf_hi", HI, 32'hFFFFFFFF);
      chk("interf_lo", LO, 32'hFFFFFFFA);
      step();
      chk("interf_idle", {31'b0, busy}, 32'h0);

      MDCCtrl = 3'b010; A = 32'd100; B = 32'd3; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_hi", HI, 32'h0);
      chk("rst_lo", LO, 32'h0);
      repeat (12) step();
      chk("rst_nowrite_hi", HI, 32'h0);
      chk("rst_nowrite_lo", LO, 32'h0);
      MDM_WE = 2'b10; A = 32'h55; step();
      MDM_WE = 2'b00; MDM_RE = 2'b10; #1;
      chk("rst_mtlo_read", MDM_out, 32'h55);
      step();

      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter MULT_CYCLES SHALL default to 5 and set the busy cycles for mult, multu and madd.
REQ-003 Parameter DIV_CYCLES SHALL default to 10 and set the busy cycles for div and divu.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the system clock.
REQ-005 Port reset SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-006 Port start SHALL be an input, 1 bit wide, and requests an operation.
REQ-007 Port MDCCtrl SHALL be an input, 3 bits wide, with these encodings:
- 000 = signed multiply
- 001 = unsigned multiply
- 010 = signed divide
- 011 = unsigned divide
- 100 = signed multiply-add
REQ-008 Port MDM_WE SHALL be an input, 2 bits wide, where 01 writes HI and 10 writes LO.
REQ-009 Port MDM_RE SHALL be an input, 2 bits wide, where 01 reads HI and 10 reads LO.
REQ-010 Port A SHALL be an input, 32 bits wide, and carries the rs operand.
REQ-011 Port B SHALL be an input, 32 bits wide, and carries the rt operand.
REQ-012 Port busy SHALL be an output, 1 bit wide, and is high while an operation is in progress.
REQ-013 Port MDM_out SHALL be an output, 32 bits wide, and carries the read data.
REQ-014 Ports HI and LO SHALL be outputs, 32 bits wide each, and expose the architectural registers.

Function
REQ-015 The FSM SHALL have two states: IDLE and RUN.
REQ-016 In IDLE, start=1 with a legal MDCCtrl (000 to 100) SHALL do all of the following at that edge:
- latch A, B and MDCCtrl
- load the counter with MULT_CYCLES or DIV_CYCLES
- enter RUN
REQ-017 busy SHALL be 1 exactly while in RUN, so it rises the cycle after the start edge and stays high for N cycles.
REQ-018 In RUN, the counter SHALL decrement every cycle; on the edge where it reaches the end, HI/LO SHALL be written, the FSM SHALL return to IDLE, and busy SHALL fall.
REQ-019 Results SHALL be visible on HI/LO and MDM_out exactly N cycles after the start edge.
REQ-020 Operations SHALL produce these results, computed from the latched operands only:
- mult: {HI,LO} = signed A × signed B, 64-bit result.
- multu: {HI,LO} = unsigned A × unsigned B, 64-bit result.
- madd: {HI,LO} = {HI,LO} + signed A × signed B, modulo 2^64, using HI/LO as they are at the completion edge.
- div: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
- divu: LO = unsigned quotient; HI = unsigned remainder.
REQ-021 Signed division 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-022 Divide with B=0 SHALL still run DIV_CYCLES with busy high, and SHALL leave HI and LO unchanged.
REQ-023 start asserted while in RUN SHALL be ignored.
REQ-024 start with an illegal MDCCtrl (101 to 111) SHALL be ignored.
REQ-025 MDM_WE SHALL be handled as follows:
- In IDLE, MDM_WE=01 SHALL write A into HI at the edge, and MDM_WE=10 SHALL write A into LO.
- Values 00 and 11 SHALL write nothing.
- In RUN, MDM_WE SHALL be ignored.
REQ-026 If start and MDM_WE are both active in the same IDLE cycle, start SHALL win and the write SHALL be discarded.
REQ-027 MDM_out SHALL be combinational: HI when MDM_RE=01, LO when MDM_RE=10, otherwise 0; it SHALL reflect current HI/LO regardless of busy.
REQ-028 Stalling the pipeline on busy, or on start in flight, SHALL be the responsibility of the hazard logic outside this block.

Reset
REQ-029 With reset=1 at a clock edge, the following SHALL happen at that edge:
- HI=0 and LO=0
- counter=0
- state=IDLE and busy=0
- latched operands cleared
REQ-030 A reset during RUN SHALL abort the operation, so no HI/LO write occurs afterwards.
REQ-031 reset SHALL take priority over start and MDM_WE in the same cycle.

Verification
REQ-032 mult scenario: A=0xFFFFFFFE, B=3, MDCCtrl=000, start for 1 cycle.
- busy high for 5 cycles.
- Then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-033 multu scenario: the same operands with MDCCtrl=001.
- HI=0x00000002 and LO=0xFFFFFFFA after 5 cycles.
REQ-034 div scenario: A=0xFFFFFFF9 (-7), B=2, MDCCtrl=010.
- busy high for 10 cycles.
- Then LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- Repeating with B=0 leaves HI/LO unchanged after 10 busy cycles.
REQ-035 madd scenario: mthi 0, mtlo 0xFFFFFFFF, then madd with A=1, B=1.
- HI=1 and LO=0 after 5 cycles.
- MDM_RE=10 then returns 0.
REQ-036 Interference scenario: start mult, then during RUN pulse start (divu) and MDM_WE=01 with A=0x1234.
- Both are ignored.
- The final HI/LO equal the mult result.
- busy stays high for exactly 5 cycles.
REQ-037 Reset scenario: reset asserted on cycle 3 of a div.
- busy=0 and HI=LO=0 on the next cycle.
- No later write occurs.
- A fresh mtlo 0x55 then reads back 0x55 on MDM_out with MDM_RE=10.
